lbfgs_history_buffer: RTL

- Stores the last NUM_LOOP L-BFGS correction pairs (s_k, y_k, rho_k) in a circular buffer.
- Serves these pairs to the search-direction unit in two-loop order: newest→oldest, then oldest→newest.
- Sits directly upstream of the search-direction unit. The unit's s_rd_en / y_rd_en / rho_rd_en strobes drive this block's three independent read streams.
- Writes come from the iteration-update stage once per accepted step.

---
 rtl/lbfgs_pkg.sv | 32 +++
 rtl/lbfgs_history_buffer_if.sv | 34 +++
 rtl/hist_read_sequencer.sv | 63 ++++++
 rtl/lbfgs_history_buffer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/lbfgs_pkg.sv
// Shared sizes, types and small index helpers for the L-BFGS history buffer.
package lbfgs_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int NUM_ELEMENTS = 50;
  localparam int NUM_LOOP     = 10;

  localparam int IDX_W  = $clog2(NUM_LOOP);
  localparam int CNT_W  = $clog2(NUM_LOOP + 1);
  localparam int KCNT_W = CNT_W + 1;

  typedef logic [DATA_WIDTH-1:0]    word_t;
  typedef word_t [NUM_ELEMENTS-1:0] vec_t;
  typedef logic [IDX_W-1:0]         idx_t;
  typedef logic [CNT_W-1:0]         cnt_t;
  typedef logic [KCNT_W-1:0]        kcnt_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  // Circular-buffer pointer steps that wrap at NUM_LOOP rather than at a power of two.
  function automatic idx_t wrap_inc(input idx_t p);
    return (p == idx_t'(NUM_LOOP - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic idx_t wrap_dec(input idx_t p);
    return (p == '0) ? idx_t'(NUM_LOOP - 1) : p - 1'b1;
  endfunction

endpackage

// File: rtl/lbfgs_history_buffer_if.sv
// Write, read-control and output bundle between the update stage, the buffer and the search-direction unit.
interface lbfgs_history_buffer_if;
  import lbfgs_pkg::*;

  logic  clear;
  logic  wr_en;
  vec_t  s_in;
  vec_t  y_in;
  word_t rho_in;
  logic  rd_start;
  logic  s_rd_en;
  logic  y_rd_en;
  logic  rho_rd_en;

  vec_t  s_out;
  vec_t  y_out;
  word_t rho_out;
  cnt_t  num_loop_current;
  logic  busy;
  logic  seq_done;
  logic  wr_err;
  logic  rd_err;

  modport master (
    output clear, wr_en, s_in, y_in, rho_in, rd_start, s_rd_en, y_rd_en, rho_rd_en,
    input  s_out, y_out, rho_out, num_loop_current, busy, seq_done, wr_err, rd_err
  );

  modport slave (
    input  clear, wr_en, s_in, y_in, rho_in, rd_start, s_rd_en, y_rd_en, rho_rd_en,
    output s_out, y_out, rho_out, num_loop_current, busy, seq_done, wr_err, rd_err
  );

endinterface

// File: rtl/hist_read_sequencer.sv
// One read stream: walks the snapshot newest->oldest then oldest->newest, one step per rd_en.
module hist_read_sequencer
  import lbfgs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic rd_start,
  input  logic rd_en,
  input  cnt_t snap_cnt,
  input  idx_t newest,
  output idx_t idx,
  output logic load,
  output logic done,
  output logic over_read
);

  kcnt_t n_q;
  cnt_t  snap_q;
  idx_t  newest_q;
  kcnt_t total;
  kcnt_t k_next;
  kcnt_t back;
  kcnt_t base;
  kcnt_t idx_wide;

  assign total = {snap_q, 1'b0};

  // n_q counts consumed words; idx is the slot shown after this edge, found as a
  // distance back from the newest slot so both halves share one wrap compare.
  always_comb begin
    k_next = n_q + 1'b1;
    base   = kcnt_t'(newest_q);
    back   = '0;
    if (rd_start) begin
      base = kcnt_t'(newest);
    end else if (k_next < kcnt_t'(snap_q)) begin
      back = k_next;
    end else begin
      back = total - k_next - 1'b1;
    end
    idx_wide  = (base >= back) ? base - back : base + kcnt_t'(NUM_LOOP) - back;
    idx       = idx_t'(idx_wide);
    load      = rd_start || (rd_en && (k_next < total));
    done      = (n_q == total) || (rd_en && (k_next == total));
    over_read = rd_en && !rd_start && (n_q == total);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      n_q      <= '0;
      snap_q   <= '0;
      newest_q <= '0;
    end else if (rd_start) begin
      n_q      <= '0;
      snap_q   <= snap_cnt;
      newest_q <= newest;
    end else if (rd_en && (n_q < total)) begin
      n_q <= k_next;
    end
  end

endmodule

// File: rtl/lbfgs_history_buffer.sv
// Circular store of the last NUM_LOOP (s, y, rho) pairs, replayed in L-BFGS two-loop order
// on three independently paced read streams.
module lbfgs_history_buffer
  import lbfgs_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  lbfgs_history_buffer_if.slave bus
);

  vec_t  s_mem   [NUM_LOOP];
  vec_t  y_mem   [NUM_LOOP];
  word_t rho_mem [NUM_LOOP];

  state_t state_q, state_d;
  idx_t   wr_ptr_q;
  cnt_t   count_q;
  idx_t   newest_now;
  logic   is_idle, start_ok, start_empty, wr_ok, wr_rej;
  logic   seq_done_d, all_done;

  idx_t  s_idx, y_idx, rho_idx;
  logic  s_load, y_load, rho_load;
  logic  s_done, y_done, rho_done;
  logic  s_over, y_over, rho_over;

  vec_t  s_q, y_q;
  word_t rho_q;
  logic  seq_done_q, wr_err_q, rd_err_q;

  assign is_idle     = (state_q == IDLE);
  assign start_ok    = bus.rd_start && is_idle && !bus.clear && (count_q != '0);
  assign start_empty = bus.rd_start && is_idle && !bus.clear && (count_q == '0);
  assign wr_ok       = bus.wr_en && is_idle && !bus.clear && !bus.rd_start;
  assign wr_rej      = bus.wr_en && !bus.clear && !wr_ok;
  assign newest_now  = wrap_dec(wr_ptr_q);
  assign all_done    = s_done && y_done && rho_done;

  hist_read_sequencer u_s_seq (
    .clk(clk), .rst(rst), .clear(bus.clear), .rd_start(start_ok), .rd_en(bus.s_rd_en),
    .snap_cnt(count_q), .newest(newest_now),
    .idx(s_idx), .load(s_load), .done(s_done), .over_read(s_over)
  );

  hist_read_sequencer u_y_seq (
    .clk(clk), .rst(rst), .clear(bus.clear), .rd_start(start_ok), .rd_en(bus.y_rd_en),
    .snap_cnt(count_q), .newest(newest_now),
    .idx(y_idx), .load(y_load), .done(y_done), .over_read(y_over)
  );

  hist_read_sequencer u_rho_seq (
    .clk(clk), .rst(rst), .clear(bus.clear), .rd_start(start_ok), .rd_en(bus.rho_rd_en),
    .snap_cnt(count_q), .newest(newest_now),
    .idx(rho_idx), .load(rho_load), .done(rho_done), .over_read(rho_over)
  );

  always_comb begin
    state_d    = state_q;
    seq_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = ACTIVE;
        if (start_empty) seq_done_d = 1'b1;
      end
      ACTIVE: begin
        if (all_done) begin
          state_d    = IDLE;
          seq_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d    = IDLE;
      seq_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      seq_done_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      s_q        <= '0;
      y_q        <= '0;
      rho_q      <= '0;
    end else begin
      state_q    <= state_d;
      seq_done_q <= seq_done_d;
      wr_err_q   <= wr_rej;
      if (bus.clear) begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (wr_ok) begin
        wr_ptr_q <= wrap_inc(wr_ptr_q);
        count_q  <= (count_q == cnt_t'(NUM_LOOP)) ? count_q : count_q + 1'b1;
      end
      if (bus.clear || (bus.rd_start && is_idle)) begin
        rd_err_q <= 1'b0;
      end else if (s_over || y_over || rho_over) begin
        rd_err_q <= 1'b1;
      end
      if (s_load && !bus.clear) s_q <= s_mem[s_idx];
      if (y_load && !bus.clear) y_q <= y_mem[y_idx];
      if (rho_load && !bus.clear) rho_q <= rho_mem[rho_idx];
    end
  end

  // Pair storage carries no reset; a full buffer simply overwrites its oldest slot.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      s_mem[wr_ptr_q]   <= bus.s_in;
      y_mem[wr_ptr_q]   <= bus.y_in;
      rho_mem[wr_ptr_q] <= bus.rho_in;
    end
  end

  assign bus.s_out            = s_q;
  assign bus.y_out            = y_q;
  assign bus.rho_out          = rho_q;
  assign bus.num_loop_current = count_q;
  assign bus.busy             = (state_q == ACTIVE);
  assign bus.seq_done         = seq_done_q;
  assign bus.wr_err           = wr_err_q;
  assign bus.rd_err           = rd_err_q;

endmodule
